posit_encoder: RTL

POSIT_ENCODER -- requirements
Module: posit_encoder

---
 rtl/posit_encoder_pkg.sv | 32 +++
 rtl/posit_encoder_round.sv | 46 ++++
 rtl/posit_encoder.sv | 114 +++++++++++
 3 files changed

// File: rtl/posit_encoder_pkg.sv
// Shared posit definitions: operand class codes, saturation tags and the
// special-value constants used by both the encoder and the decoder.
package posit_encoder_pkg;

  localparam logic [1:0] FLAG_ZERO  = 2'b00;
  localparam logic [1:0] FLAG_VALID = 2'b01;
  localparam logic [1:0] FLAG_NAR   = 2'b10;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_MAX  = 2'd1,
    SAT_MIN  = 2'd2
  } sat_e;

  function automatic int regi_w(input int width);
    return $clog2(width) + 1;
  endfunction

  // Constants are returned 64 bits wide; callers slice to their word width.
  function automatic logic [63:0] maxpos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] minpos(input int width);
    return (width > 0) ? 64'd1 : 64'd0;
  endfunction

  function automatic logic [63:0] nar(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/posit_encoder_round.sv
// Round-to-nearest-even, saturation to maxpos/minpos, sign and special-class
// handling for one truncated magnitude string.
module posit_round
  import posit_encoder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       flag_i,
  input  logic             sign_i,
  input  sat_e             sat_i,
  input  logic [WIDTH-2:0] body_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  output logic [WIDTH-1:0] word_o
);

  localparam logic [63:0] MAXPOS64 = maxpos(WIDTH);
  localparam logic [63:0] MINPOS64 = minpos(WIDTH);
  localparam logic [63:0] NAR64    = nar(WIDTH);
  localparam logic [WIDTH-1:0] MAXPOS = MAXPOS64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MINPOS = MINPOS64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] NAR    = NAR64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic             inc;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] mag;

  always_comb begin
    inc = guard_i & (sticky_i | body_i[0]);
    sum = {1'b0, body_i} + {{(WIDTH-1){1'b0}}, inc};
    mag = sum;
    // A carry into the sign position means the value overflowed the format.
    if (sat_i == SAT_MAX || sum[WIDTH-1]) begin
      mag = MAXPOS;
    end else if (sat_i == SAT_MIN || sum == '0) begin
      mag = MINPOS;
    end
    case (flag_i)
      FLAG_ZERO:  word_o = '0;
      FLAG_VALID: word_o = sign_i ? (~mag + ONE) : mag;
      default:    word_o = NAR;
    endcase
  end

endmodule

// File: rtl/posit_encoder.sv
// Two-stage posit encoder: S1 assembles and aligns the regime/exp/frac string,
// S2 rounds and registers the word. Stages move on valid&ready handshakes.
module posit_encoder
  import posit_encoder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int EXP   = 2,
  parameter int FRAC  = 8
) (
  input  logic                           clk_i,
  input  logic                           rstn,
  input  logic                           vld_i,
  output logic                           rdy_o,
  input  logic [1:0]                     flag_i,
  input  logic                           sign_i,
  input  logic signed [regi_w(WIDTH)-1:0] regi_i,
  input  logic [EXP-1:0]                 exp_i,
  input  logic [FRAC-1:0]                frac_i,
  output logic                           vld_o,
  input  logic                           rdy_i,
  output logic [WIDTH-1:0]               pout
);

  localparam int RW = regi_w(WIDTH);
  localparam int SW = RW + 1;
  localparam int FW = WIDTH + EXP + FRAC;
  localparam logic signed [RW-1:0] K_MAX = RW'(WIDTH - 2);
  localparam logic signed [RW-1:0] K_MIN = -K_MAX;
  localparam logic [RW:0] SH_POS = SW'(WIDTH - 2);
  localparam logic [RW:0] SH_NEG = SW'(WIDTH - 1);

  logic s1_adv, s2_adv;
  logic run;
  logic [RW:0] kx, sh;
  logic [FW-1:0] full, full_sh;
  sat_e sat;

  logic             s1_vld_q;
  logic [1:0]       s1_flag_q;
  logic             s1_sign_q;
  sat_e             s1_sat_q;
  logic [WIDTH-2:0] s1_body_q;
  logic             s1_guard_q;
  logic             s1_sticky_q;
  logic             s2_vld_q;
  logic [WIDTH-1:0] pout_q, pout_d;

  assign s2_adv = ~s2_vld_q | rdy_i;
  assign s1_adv = ~s1_vld_q | s2_adv;
  assign rdy_o  = s1_adv;
  assign vld_o  = s2_vld_q;
  assign pout   = pout_q;

  // The regime run is pre-filled to its longest length; shifting left trims
  // it to the length k calls for and left-aligns the whole string.
  always_comb begin
    run = ~regi_i[RW-1];
    kx  = {regi_i[RW-1], regi_i};
    sh  = run ? (SH_POS - kx) : (SH_NEG + kx);
    sat = SAT_NONE;
    if (regi_i >= K_MAX) begin
      sat = SAT_MAX;
    end else if (regi_i < K_MIN) begin
      sat = SAT_MIN;
    end
    full    = {{(WIDTH-1){run}}, ~run, exp_i, frac_i};
    full_sh = (sat == SAT_NONE) ? (full << sh) : '0;
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q    <= 1'b0;
      s1_flag_q   <= FLAG_ZERO;
      s1_sign_q   <= 1'b0;
      s1_sat_q    <= SAT_NONE;
      s1_body_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
    end else if (s1_adv) begin
      s1_vld_q <= vld_i;
      if (vld_i) begin
        s1_flag_q   <= flag_i;
        s1_sign_q   <= sign_i;
        s1_sat_q    <= sat;
        s1_body_q   <= full_sh[FW-1 -: WIDTH-1];
        s1_guard_q  <= full_sh[FW-WIDTH];
        s1_sticky_q <= |full_sh[FW-WIDTH-1:0];
      end
    end
  end

  posit_round #(.WIDTH(WIDTH)) u_round (
    .flag_i  (s1_flag_q),
    .sign_i  (s1_sign_q),
    .sat_i   (s1_sat_q),
    .body_i  (s1_body_q),
    .guard_i (s1_guard_q),
    .sticky_i(s1_sticky_q),
    .word_o  (pout_d)
  );

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      s2_vld_q <= 1'b0;
      pout_q   <= '0;
    end else if (s2_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        pout_q <= pout_d;
      end
    end
  end

endmodule
